// File: rtl/alu_input_sequencer.sv
// Board-side front end for the ALU demo: debounced step/clear buttons walk operand
// and opcode entry from the slide switches, then latch the ALU result for display.
module alu_input_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  sw,
  input  logic        btn_step_n,
  input  logic        btn_clear_n,
  input  logic [15:0] alu_out,
  input  logic [4:0]  alu_flags,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [15:0] alu_control,
  output logic        alu_valid,
  output logic [15:0] result_q,
  output logic [4:0]  flags_q,
  output logic [15:0] disp_value,
  output logic [2:0]  state_code
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned NB = 2;

  typedef enum logic [2:0] {
    A_LO = 3'd0,
    A_HI = 3'd1,
    B_LO = 3'd2,
    B_HI = 3'd3,
    OP   = 3'd4,
    EXEC = 3'd5,
    SHOW = 3'd6
  } state_t;

  state_t state, state_d;

  logic [7:0]    sw_s1, sw_s2;
  logic [NB-1:0] btn_raw, btn_s1, btn_s2, btn_stable, btn_press;
  logic [CW-1:0] btn_cnt [NB];
  logic          step_p, clear_p;

  logic [15:0] a_d, b_d, res_d, disp_d;
  logic [7:0]  op_q, op_d;
  logic [4:0]  flags_d;
  logic        valid_d;

  // Button bit 0 is step, bit 1 is clear; both active-low, so 1 = not pressed.
  assign btn_raw = {btn_clear_n, btn_step_n};

  // Synchronizers and per-button debounce: accept a level only after it holds DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_s1      <= '0;
      sw_s2      <= '0;
      btn_s1     <= '1;
      btn_s2     <= '1;
      btn_stable <= '1;
      for (int i = 0; i < NB; i++) btn_cnt[i] <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      for (int i = 0; i < NB; i++) begin
        if (btn_s2[i] != btn_stable[i]) begin
          if (btn_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_stable[i] <= btn_s2[i];
            btn_cnt[i]    <= '0;
          end else begin
            btn_cnt[i] <= btn_cnt[i] + CW'(1);
          end
        end else begin
          btn_cnt[i] <= '0;
        end
      end
    end
  end

  // One-cycle pulse on the cycle a not-pressed -> pressed change is accepted.
  always_comb begin
    btn_press = '0;
    for (int i = 0; i < NB; i++) begin
      btn_press[i] = btn_stable[i] && !btn_s2[i] && (btn_cnt[i] == CW'(DEBOUNCE_CYCLES - 1));
    end
  end

  assign step_p  = btn_press[0];
  assign clear_p = btn_press[1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= A_LO;
    else        state <= state_d;
  end

  // Next state, register updates and display selection.
  always_comb begin
    state_d = state;
    a_d     = alu_a;
    b_d     = alu_b;
    op_d    = op_q;
    res_d   = result_q;
    flags_d = flags_q;
    disp_d  = result_q;

    case (state)
      A_LO:    disp_d = {alu_a[15:8], sw_s2};
      A_HI:    disp_d = {sw_s2, alu_a[7:0]};
      B_LO:    disp_d = {alu_b[15:8], sw_s2};
      B_HI:    disp_d = {sw_s2, alu_b[7:0]};
      OP:      disp_d = {8'h00, sw_s2};
      default: disp_d = result_q;
    endcase

    if (clear_p) begin
      state_d = A_LO;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      res_d   = '0;
      flags_d = '0;
    end else begin
      case (state)
        A_LO: if (step_p) begin a_d[7:0]  = sw_s2; state_d = A_HI; end
        A_HI: if (step_p) begin a_d[15:8] = sw_s2; state_d = B_LO; end
        B_LO: if (step_p) begin b_d[7:0]  = sw_s2; state_d = B_HI; end
        B_HI: if (step_p) begin b_d[15:8] = sw_s2; state_d = OP;   end
        OP:   if (step_p) begin op_d      = sw_s2; state_d = EXEC; end
        EXEC: begin
          res_d   = alu_out;
          flags_d = alu_flags;
          state_d = SHOW;
        end
        SHOW: if (step_p) state_d = A_LO;
        default: state_d = A_LO;
      endcase
    end

    valid_d = (state_d == EXEC) || (state_d == SHOW);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      op_q       <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      alu_valid  <= 1'b0;
      disp_value <= '0;
    end else begin
      alu_a      <= a_d;
      alu_b      <= b_d;
      op_q       <= op_d;
      result_q   <= res_d;
      flags_q    <= flags_d;
      alu_valid  <= valid_d;
      disp_value <= disp_d;
    end
  end

  assign alu_control = {8'h00, op_q};
  assign state_code  = state;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Bench for alu_input_sequencer: fixed entry table, hand-written button corner cases,
// and randomized step/clear traffic against an operation-level reference model.
module tb_alu_input_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  sw;
  logic        btn_step_n, btn_clear_n;
  logic [15:0] alu_out;
  logic [4:0]  alu_flags;
  logic [15:0] alu_a, alu_b, alu_control, result_q, disp_value;
  logic        alu_valid;
  logic [4:0]  flags_q;
  logic [2:0]  state_code;
  logic [16:0] sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stub ALU: add with carry flag in bit 0.
  assign sum       = {1'b0, alu_a} + {1'b0, alu_b};
  assign alu_out   = sum[15:0];
  assign alu_flags = {4'b0, sum[16]};

  alu_input_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .sw(sw), .btn_step_n(btn_step_n), .btn_clear_n(btn_clear_n),
    .alu_out(alu_out), .alu_flags(alu_flags), .alu_a(alu_a), .alu_b(alu_b),
    .alu_control(alu_control), .alu_valid(alu_valid), .result_q(result_q), .flags_q(flags_q),
    .disp_value(disp_value), .state_code(state_code)
  );

  // Reference model: entry position 0..4, then 6 once a result is shown.
  int          m_state;
  logic [15:0] m_a, m_b, m_res;
  logic [7:0]  m_op;
  logic [4:0]  m_fl;

  task automatic model_clear();
    m_state = 0; m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_fl = '0;
  endtask

  task automatic model_step(input logic [7:0] v);
    logic [16:0] s;
    case (m_state)
      0: begin m_a = {m_a[15:8], v}; m_state = 1; end
      1: begin m_a = {v, m_a[7:0]};  m_state = 2; end
      2: begin m_b = {m_b[15:8], v}; m_state = 3; end
      3: begin m_b = {v, m_b[7:0]};  m_state = 4; end
      4: begin
        m_op = v;
        s = 17'(m_a) + 17'(m_b);
        m_res = s[15:0];
        m_fl = {4'b0, s[16]};
        m_state = 6;
      end
      default: m_state = 0;
    endcase
  endtask

  function automatic logic [15:0] model_disp(input logic [7:0] v);
    case (m_state)
      0: return {m_a[15:8], v};
      1: return {v, m_a[7:0]};
      2: return {m_b[15:8], v};
      3: return {v, m_b[7:0]};
      4: return {8'h00, v};
      default: return m_res;
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".state"}, 16'(state_code), 16'(m_state));
    chk({tag, ".a"},     alu_a, m_a);
    chk({tag, ".b"},     alu_b, m_b);
    chk({tag, ".ctl"},   alu_control, {8'h00, m_op});
    chk({tag, ".res"},   result_q, m_res);
    chk({tag, ".flags"}, 16'(flags_q), 16'(m_fl));
    chk({tag, ".valid"}, 16'(alu_valid), 16'(m_state >= 5));
    chk({tag, ".disp"},  disp_value, model_disp(sw));
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Set switches, then press the selected button(s) for 'hold' cycles and release fully.
  task automatic press(input bit do_step, input bit do_clear, input logic [7:0] v, input int hold);
    sw = v;
    tick(3);
    if (do_step)  btn_step_n  = 1'b0;
    if (do_clear) btn_clear_n = 1'b0;
    tick(hold);
    btn_step_n  = 1'b1;
    btn_clear_n = 1'b1;
    tick(10);
  endtask

  typedef struct {
    logic [7:0]  sw;
    logic [2:0]  st;
    logic [15:0] a, b, ctl, res;
    logic [4:0]  fl;
    logic [15:0] disp;
  } row_t;

  row_t tbl [11];
  logic [4:0] bounce;

  initial begin
    tbl[0]  = '{8'h34, 3'd1, 16'h0034, 16'h0000, 16'h0000, 16'h0000, 5'h00, 16'h3434};
    tbl[1]  = '{8'h12, 3'd2, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 5'h00, 16'h0012};
    tbl[2]  = '{8'h0F, 3'd3, 16'h1234, 16'h000F, 16'h0000, 16'h0000, 5'h00, 16'h0F0F};
    tbl[3]  = '{8'h0F, 3'd4, 16'h1234, 16'h0F0F, 16'h0000, 16'h0000, 5'h00, 16'h000F};
    tbl[4]  = '{8'h05, 3'd6, 16'h1234, 16'h0F0F, 16'h0005, 16'h2143, 5'h00, 16'h2143};
    tbl[5]  = '{8'hFF, 3'd0, 16'h1234, 16'h0F0F, 16'h0005, 16'h2143, 5'h00, 16'h12FF};
    tbl[6]  = '{8'hFF, 3'd1, 16'h12FF, 16'h0F0F, 16'h0005, 16'h2143, 5'h00, 16'hFFFF};
    tbl[7]  = '{8'hFF, 3'd2, 16'hFFFF, 16'h0F0F, 16'h0005, 16'h2143, 5'h00, 16'h0FFF};
    tbl[8]  = '{8'h01, 3'd3, 16'hFFFF, 16'h0F01, 16'h0005, 16'h2143, 5'h00, 16'h0101};
    tbl[9]  = '{8'h00, 3'd4, 16'hFFFF, 16'h0001, 16'h0005, 16'h2143, 5'h00, 16'h0000};
    tbl[10] = '{8'h07, 3'd6, 16'hFFFF, 16'h0001, 16'h0007, 16'h0000, 5'h01, 16'h0000};

    // Reset with both buttons held; release together with reset so no press is accepted.
    rst_n = 1'b0; sw = 8'h00; btn_step_n = 1'b0; btn_clear_n = 1'b0;
    model_clear();
    tick(3);
    check_model("reset");
    rst_n = 1'b1; btn_step_n = 1'b1; btn_clear_n = 1'b1;
    tick(12);
    check_model("reset_release");

    // Full entry, carry case and re-entry from SHOW.
    for (int i = 0; i < 11; i++) begin
      press(1'b1, 1'b0, tbl[i].sw, 4);
      model_step(tbl[i].sw);
      chk($sformatf("tbl%0d.state", i), 16'(state_code), 16'(tbl[i].st));
      chk($sformatf("tbl%0d.a", i),     alu_a, tbl[i].a);
      chk($sformatf("tbl%0d.b", i),     alu_b, tbl[i].b);
      chk($sformatf("tbl%0d.ctl", i),   alu_control, tbl[i].ctl);
      chk($sformatf("tbl%0d.res", i),   result_q, tbl[i].res);
      chk($sformatf("tbl%0d.flags", i), 16'(flags_q), 16'(tbl[i].fl));
      chk($sformatf("tbl%0d.valid", i), 16'(alu_valid), 16'(tbl[i].st == 3'd6));
      chk($sformatf("tbl%0d.disp", i),  disp_value, tbl[i].disp);
    end

    // Reset while showing a result.
    rst_n = 1'b0;
    tick(2);
    model_clear();
    chk("show_reset.disp", disp_value, 16'h0000);
    chk("show_reset.state", 16'(state_code), 16'd0);
    rst_n = 1'b1;
    tick(5);
    check_model("show_reset");

    // Clear in B_HI.
    press(1'b1, 1'b0, 8'h34, 4); model_step(8'h34);
    press(1'b1, 1'b0, 8'h12, 4); model_step(8'h12);
    press(1'b1, 1'b0, 8'hAB, 4); model_step(8'hAB);
    check_model("pre_clear");
    press(1'b0, 1'b1, 8'h00, 4); model_clear();
    check_model("clear");

    // Short bounce must not step.
    bounce = 5'b00100;
    sw = 8'h3C;
    tick(3);
    for (int i = 0; i < 5; i++) begin
      btn_step_n = bounce[4 - i];
      tick(1);
    end
    btn_step_n = 1'b1;
    tick(10);
    check_model("bounce");

    // Minimum accepted hold and a long hold each step exactly once.
    press(1'b1, 1'b0, 8'hAA, 4);   model_step(8'hAA);
    check_model("hold4");
    press(1'b1, 1'b0, 8'hBB, 100); model_step(8'hBB);
    check_model("hold100");

    // Step and clear accepted together: clear wins.
    press(1'b1, 1'b1, 8'h55, 4); model_clear();
    check_model("step_and_clear");

    // Random traffic against the model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] v;
      int hold;
      v = 8'($urandom);
      hold = int'($urandom_range(4, 12));
      if ($urandom_range(0, 9) < 2) begin
        press(1'b0, 1'b1, v, hold);
        model_clear();
      end else begin
        press(1'b1, 1'b0, v, hold);
        model_step(v);
      end
      check_model($sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
